// File: rtl/point_ctrl_pkg.sv
// Shared definitions for the point reader scheduler: cloud/beat geometry,
// the controller state encoding and the job error codes.
package point_ctrl_pkg;

    localparam int CLOUD_W = 512;
    localparam int BEAT_W  = 128;
    localparam int BEATS   = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        STREAM,
        DONE
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_PROTO   = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick among NUM_SRC requesters.
// Ports:
//   req        - request vector, one bit per source
//   mask       - sources excluded from this pick
//   last_grant - most recently granted source; search starts one past it
//   any        - at least one unmasked request is present
//   grant_idx  - chosen source (valid when any is high)
module rr_arbiter
    import point_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] mask,
    input  logic [SRC_W-1:0]   last_grant,
    output logic               any,
    output logic [SRC_W-1:0]   grant_idx
);

    logic [NUM_SRC-1:0] eligible;
    int                 cand;

    assign eligible = req & ~mask;

    // Walk the sources starting just after last_grant, wrapping modulo
    // NUM_SRC; the first eligible one wins.
    always_comb begin
        any       = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand = int'(last_grant) + i;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            if (!any && eligible[cand[SRC_W-1:0]]) begin
                any       = 1'b1;
                grant_idx = cand[SRC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/point_read_scheduler.sv
// Shares one 512->128-bit point reader between NUM_SRC producers. Grants one
// requester at a time, latches its cloud, starts the reader, forwards the four
// returned beats tagged with source and beat index, and closes each job with
// an ack (plus err/err_code on timeout or reader protocol violation).
// Ports:
//   clk, reset               - clock, async active-high reset
//   req / src_cloud          - per-source request level and cloud
//   ack / err / err_code     - job completion pulse and status
//   rd_start / rd_cloud      - reader start pulse and latched cloud
//   rd_data/rd_valid/rd_done - reader beat stream
//   out_*                    - registered forwarded beat
//
// state  | meaning
// IDLE   | pick next requester round-robin, latch its cloud
// START  | pulse rd_start, arm beat counter and watchdog
// STREAM | forward beats, check rd_done, watch for timeout
// DONE   | ack pulse visible, arm one-cycle re-grant mask
module point_read_scheduler
    import point_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC),
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SRC-1:0]         req,
    input  logic [NUM_SRC*CLOUD_W-1:0] src_cloud,
    output logic [NUM_SRC-1:0]         ack,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic                       rd_start,
    output logic [CLOUD_W-1:0]         rd_cloud,
    input  logic [BEAT_W-1:0]          rd_data,
    input  logic                       rd_valid,
    input  logic                       rd_done,
    output logic [BEAT_W-1:0]          out_data,
    output logic                       out_valid,
    output logic [SRC_W-1:0]           out_src,
    output logic [1:0]                 out_beat
);

    localparam int WD_W = $clog2(TIMEOUT);

    state_t             state;
    logic [SRC_W-1:0]   grant_id;
    logic [SRC_W-1:0]   last_grant;
    logic [1:0]         beat_cnt;
    logic [WD_W-1:0]    wd_cnt;
    logic               err_proto;
    logic               mask_en;

    logic               arb_any;
    logic [SRC_W-1:0]   arb_idx;
    logic [NUM_SRC-1:0] arb_mask;
    logic [NUM_SRC-1:0] grant_onehot;
    logic [CLOUD_W-1:0] sel_cloud;
    logic               last_beat;
    logic               proto_bad;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_arb (
        .req        (req),
        .mask       (arb_mask),
        .last_grant (last_grant),
        .any        (arb_any),
        .grant_idx  (arb_idx)
    );

    // Only in the first IDLE cycle after DONE is the just-served source hidden,
    // so a requester still holding req cannot be granted twice in a row.
    always_comb begin
        arb_mask = '0;
        if (mask_en) begin
            arb_mask[grant_id] = 1'b1;
        end
    end

    always_comb begin
        grant_onehot           = '0;
        grant_onehot[grant_id] = 1'b1;
    end

    always_comb begin
        sel_cloud = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (arb_idx == SRC_W'(i)) begin
                sel_cloud = src_cloud[i*CLOUD_W +: CLOUD_W];
            end
        end
    end

    assign last_beat = (beat_cnt == 2'(BEATS-1));
    // rd_done must be low on beats 0..2 and high on the final beat.
    assign proto_bad = rd_valid && (rd_done != last_beat);

    // Watchdog is a down-counter loaded in START so that its terminal count
    // lands DONE exactly TIMEOUT cycles after rd_start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= SRC_W'(NUM_SRC-1);
            beat_cnt   <= '0;
            wd_cnt     <= '0;
            err_proto  <= 1'b0;
            mask_en    <= 1'b0;
            ack        <= '0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            rd_start   <= 1'b0;
            rd_cloud   <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_src    <= '0;
            out_beat   <= '0;
        end else begin
            rd_start  <= 1'b0;
            ack       <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    mask_en <= 1'b0;
                    if (arb_any) begin
                        grant_id   <= arb_idx;
                        last_grant <= arb_idx;
                        rd_cloud   <= sel_cloud;
                        rd_start   <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    beat_cnt  <= '0;
                    wd_cnt    <= WD_W'(TIMEOUT-2);
                    err_proto <= 1'b0;
                    state     <= STREAM;
                end
                STREAM: begin
                    if (rd_valid) begin
                        out_data  <= rd_data;
                        out_src   <= grant_id;
                        out_beat  <= beat_cnt;
                        out_valid <= 1'b1;
                        beat_cnt  <= beat_cnt + 2'd1;
                        if (proto_bad) begin
                            err_proto <= 1'b1;
                        end
                    end
                    // Timeout wins over a protocol error seen in the same job.
                    if (wd_cnt == '0) begin
                        state    <= DONE;
                        ack      <= grant_onehot;
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end else begin
                        wd_cnt <= wd_cnt - WD_W'(1);
                        if (rd_valid && last_beat) begin
                            state <= DONE;
                            ack   <= grant_onehot;
                            if (err_proto || proto_bad) begin
                                err      <= 1'b1;
                                err_code <= ERR_PROTO;
                            end
                        end
                    end
                end
                DONE: begin
                    err_proto <= 1'b0;
                    mask_en   <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_point_read_scheduler.sv
// Scoreboard bench for point_read_scheduler: a reader model answers rd_start,
// expected beats/acks are queued at each grant and popped by a monitor.
module tb_point_read_scheduler;
    import point_ctrl_pkg::*;

    localparam int NUM_SRC = 4;
    localparam int SRC_W   = 2;
    localparam int TIMEOUT = 16;
    localparam int M_NORMAL  = 0;
    localparam int M_TIMEOUT = 1;
    localparam int M_PROTO   = 2;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NUM_SRC-1:0]         req;
    logic [NUM_SRC*CLOUD_W-1:0] src_cloud;
    logic [NUM_SRC-1:0]         ack;
    logic                       err;
    logic [1:0]                 err_code;
    logic                       rd_start;
    logic [CLOUD_W-1:0]         rd_cloud;
    logic [BEAT_W-1:0]          rd_data;
    logic                       rd_valid;
    logic                       rd_done;
    logic [BEAT_W-1:0]          out_data;
    logic                       out_valid;
    logic [SRC_W-1:0]           out_src;
    logic [1:0]                 out_beat;

    point_read_scheduler #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .src_cloud(src_cloud),
        .ack(ack), .err(err), .err_code(err_code),
        .rd_start(rd_start), .rd_cloud(rd_cloud),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done),
        .out_data(out_data), .out_valid(out_valid), .out_src(out_src), .out_beat(out_beat)
    );

    always #5 clk = ~clk;

    logic [CLOUD_W-1:0] src [NUM_SRC];
    always_comb begin
        src_cloud = '0;
        for (int i = 0; i < NUM_SRC; i++) src_cloud[i*CLOUD_W +: CLOUD_W] = src[i];
    end

    int cyc = 0;
    logic [NUM_SRC-1:0] req_seen = '0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        req_seen <= req;
    end

    typedef struct { int src; int beat; logic [BEAT_W-1:0] data; } beat_t;
    typedef struct { logic [NUM_SRC-1:0] ackv; logic e; logic [1:0] code; } ack_t;
    beat_t beat_q[$];
    ack_t  ack_q[$];

    int checks = 0;
    int errors = 0;
    int reader_mode = M_NORMAL;
    int ack_count[NUM_SRC];
    int model_last = NUM_SRC-1;
    int last_ack_cyc = -100;

    task automatic check(input string name, input logic [CLOUD_W-1:0] act, input logic [CLOUD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not seen within bound", name);
    endtask

    function automatic logic [CLOUD_W-1:0] rand_cloud();
        logic [CLOUD_W-1:0] v;
        v = '0;
        for (int i = 0; i < CLOUD_W/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Round-robin rule: first requesting source after the last one served,
    // skipping the source excluded by the post-ack mask.
    function automatic int predict(input logic [NUM_SRC-1:0] r, input int last, input int masked);
        for (int i = 1; i <= NUM_SRC; i++) begin
            int c;
            c = (last + i) % NUM_SRC;
            if (r[c] && c != masked) return c;
        end
        return -1;
    endfunction

    // Reader model: answers each start with beats two cycles later.
    initial begin
        int m;
        int nb;
        rd_valid = 1'b0;
        rd_done  = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge clk);
            if (rd_start === 1'b1 && reset === 1'b0) begin
                m  = reader_mode;
                nb = (m == M_TIMEOUT) ? 2 : 4;
                rd_done = 1'b0;
                @(negedge clk);
                for (int b = 0; b < nb; b++) begin
                    @(negedge clk);
                    rd_valid = 1'b1;
                    rd_data  = BEAT_W'(rd_cloud >> (b*BEAT_W));
                    rd_done  = (m == M_PROTO) ? (b >= 1) : (b == 3);
                end
                @(negedge clk);
                rd_valid = 1'b0;
                rd_data  = '0;
            end
        end
    end

    // Monitor: pops an expectation whenever the DUT presents a beat or ack.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (out_valid === 1'b1) begin
                if (beat_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: src %0d beat %0d, none expected", out_src, out_beat);
                end else begin
                    beat_t e;
                    e = beat_q.pop_front();
                    check_int("out_src", int'(out_src), e.src);
                    check_int("out_beat", int'(out_beat), e.beat);
                    check("out_data", out_data, e.data);
                end
            end
            if (ack !== '0) begin
                for (int i = 0; i < NUM_SRC; i++) if (ack[i]) ack_count[i]++;
                if (ack_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: got %b, none expected", ack);
                end else begin
                    ack_t a;
                    a = ack_q.pop_front();
                    check("ack", ack, a.ackv);
                    check("err", err, a.e);
                    if (a.e) check("err_code", err_code, a.code);
                end
            end else if (err === 1'b1) begin
                checks++; errors++;
                $display("FAIL err_without_ack: got err=1 expected 0");
            end
        end
    end

    // Waits for rd_start, queues expectations, waits for ack and checks timing.
    task automatic run_job(input int mode, input int ref_cyc, input int exp_gap);
        bit seen;
        int g;
        int mask_src;
        int nb;
        int start_cyc;
        logic [1:0] code;
        reader_mode = mode;
        seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (rd_start === 1'b1) seen = 1;
        end
        if (!seen) begin
            fail_now("rd_start_wait");
            return;
        end
        start_cyc = cyc;
        if (exp_gap > 0) check_int("start_gap", start_cyc - ref_cyc, exp_gap);
        mask_src = (start_cyc == last_ack_cyc + 2) ? model_last : -1;
        g = predict(req_seen, model_last, mask_src);
        if (g < 0) begin
            checks++; errors++;
            $display("FAIL grant: got start with req %b, expected no grant", req_seen);
            return;
        end
        check("rd_cloud", rd_cloud, src[g]);
        nb = (mode == M_TIMEOUT) ? 2 : 4;
        for (int b = 0; b < nb; b++)
            beat_q.push_back('{src: g, beat: b, data: BEAT_W'(src[g] >> (b*BEAT_W))});
        code = (mode == M_TIMEOUT) ? ERR_TIMEOUT : (mode == M_PROTO) ? ERR_PROTO : ERR_NONE;
        ack_q.push_back('{ackv: NUM_SRC'(1) << g, e: (mode != M_NORMAL), code: code});
        model_last = g;
        seen = 0;
        for (int k = 0; k < TIMEOUT + 20 && !seen; k++) begin
            @(negedge clk);
            if (ack !== '0) seen = 1;
        end
        if (!seen) begin
            fail_now("ack_wait");
            return;
        end
        check_int("ack_latency", cyc - start_cyc, (mode == M_TIMEOUT) ? TIMEOUT : 6);
        last_ack_cyc = cyc;
    endtask

    initial begin
        int cnt0[NUM_SRC];
        int mode;
        int gap;
        int g;
        bit seen;
        logic [NUM_SRC-1:0] r;
        for (int i = 0; i < NUM_SRC; i++) begin
            src[i] = rand_cloud();
            ack_count[i] = 0;
        end
        reset = 1'b1;
        req   = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", ack, '0);
        check("rst_err", err, '0);
        check("rst_err_code", err_code, '0);
        check("rst_rd_start", rd_start, '0);
        check("rst_rd_cloud", rd_cloud, '0);
        check("rst_out_valid", out_valid, '0);
        check("rst_out_data", out_data, '0);
        check("rst_out_src", out_src, '0);
        check("rst_out_beat", out_beat, '0);
        #1 reset = 1'b0;

        // Single request with four distinct words.
        @(negedge clk);
        src[0] = {128'h44444444_44444444_dddddddd_dddddddd, 128'h33333333_33333333_cccccccc_cccccccc,
                  128'h22222222_22222222_bbbbbbbb_bbbbbbbb, 128'h11111111_11111111_aaaaaaaa_aaaaaaaa};
        req = 4'b0001;
        run_job(M_NORMAL, cyc, 1);
        req = '0;

        // Fairness: all sources requesting continuously.
        for (int i = 0; i < NUM_SRC; i++) cnt0[i] = ack_count[i];
        req = 4'b1111;
        for (int j = 0; j < 8; j++) run_job(M_NORMAL, last_ack_cyc, 2);
        for (int i = 0; i < NUM_SRC; i++) check_int("fair_acks", ack_count[i] - cnt0[i], 2);

        // Ack mask: lone requester held past its ack waits one extra cycle.
        req = 4'b0100;
        run_job(M_NORMAL, last_ack_cyc, 2);
        run_job(M_NORMAL, last_ack_cyc, 3);

        // Timeout, then a normal job from the same source.
        req = 4'b0001;
        run_job(M_TIMEOUT, last_ack_cyc, 2);
        run_job(M_NORMAL, last_ack_cyc, 3);

        // Protocol error.
        req = 4'b1000;
        run_job(M_PROTO, last_ack_cyc, 2);

        // Randomized jobs.
        for (int j = 0; j < 20; j++) begin
            for (int i = 0; i < NUM_SRC; i++) src[i] = rand_cloud();
            r = NUM_SRC'($urandom_range(1, (1 << NUM_SRC) - 1));
            req = r;
            mode = $urandom_range(0, 5);
            mode = (mode == 4) ? M_TIMEOUT : (mode == 5) ? M_PROTO : M_NORMAL;
            gap = ((r & ~(NUM_SRC'(1) << model_last)) != '0) ? 2 : 3;
            run_job(mode, last_ack_cyc, gap);
        end

        // Reset in the middle of a stream.
        req = 4'b0011;
        reader_mode = M_NORMAL;
        seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (rd_start === 1'b1) seen = 1;
        end
        if (!seen) begin
            fail_now("rst_job_start");
        end else begin
            g = predict(req_seen, model_last, (cyc == last_ack_cyc + 2) ? model_last : -1);
            for (int b = 0; b < 3; b++)
                beat_q.push_back('{src: g, beat: b, data: BEAT_W'(src[g] >> (b*BEAT_W))});
            repeat (5) @(negedge clk);
            #1 reset = 1'b1;
            beat_q.delete();
            ack_q.delete();
            #1;
            check("mid_rst_ack", ack, '0);
            check("mid_rst_err", err, '0);
            check("mid_rst_out_valid", out_valid, '0);
            check("mid_rst_rd_cloud", rd_cloud, '0);
            check("mid_rst_out_data", out_data, '0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("rst_hold_ack", ack, '0);
                check("rst_hold_rd_start", rd_start, '0);
            end
            #1 reset = 1'b0;
            model_last = NUM_SRC-1;
            last_ack_cyc = -100;
            run_job(M_NORMAL, cyc, 1);
        end
        req = '0;

        repeat (4) @(negedge clk);
        check_int("beat_q_empty", beat_q.size(), 0);
        check_int("ack_q_empty", ack_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
